// File: rtl/demux1_4_buf.sv
// rtl/demux1_4_buf.sv - buffered 1-to-4 stream demultiplexer with per-channel FIFOs
// One producer steers words by S into four independent circular-buffer FIFOs.
module demux1_4_buf #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = ($clog2(DEPTH + 1) < 3) ? 3 : $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     InData,
   input  logic                 InValid,
   input  logic [1:0]           S,
   output logic                 InReady,
   output logic [4*WIDTH-1:0]   OutData,
   output logic [3:0]           OutValid,
   input  logic [3:0]           OutReady,
   output logic [4*LW-1:0]      Level
);

   logic [WIDTH-1:0] mem_q [4][DEPTH];
   logic [AW-1:0]    rd_q  [4];
   logic [AW-1:0]    rd_d  [4];
   logic [AW-1:0]    wr_q  [4];
   logic [AW-1:0]    wr_d  [4];
   logic [LW-1:0]    cnt_q [4];
   logic [LW-1:0]    cnt_d [4];
   logic [3:0]       full;
   logic [3:0]       push;
   logic [3:0]       pop;

   always_comb begin
      full     = '0;
      OutValid = '0;
      OutData  = '0;
      Level    = '0;
      for (int i = 0; i < 4; i++) begin
         full[i]                   = (cnt_q[i] == LW'(DEPTH));
         OutValid[i]               = (cnt_q[i] != '0);
         OutData[i*WIDTH +: WIDTH] = mem_q[i][rd_q[i]];
         Level[i*LW +: LW]         = cnt_q[i];
      end
   end

   // A pop on a full channel does not free the slot until the next cycle.
   assign InReady = rst_n & ~full[S];

   always_comb begin
      push = '0;
      pop  = '0;
      for (int i = 0; i < 4; i++) begin
         push[i]  = InValid & InReady & (S == 2'(i));
         pop[i]   = OutValid[i] & OutReady[i];
         wr_d[i]  = wr_q[i] + AW'(push[i]);
         rd_d[i]  = rd_q[i] + AW'(pop[i]);
         cnt_d[i] = cnt_q[i] + LW'(push[i]) - LW'(pop[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            rd_q[i]  <= '0;
            wr_q[i]  <= '0;
            cnt_q[i] <= '0;
            for (int j = 0; j < DEPTH; j++) begin
               mem_q[i][j] <= '0;
            end
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            rd_q[i]  <= rd_d[i];
            wr_q[i]  <= wr_d[i];
            cnt_q[i] <= cnt_d[i];
            if (push[i]) begin
               mem_q[i][wr_q[i]] <= InData;
            end
         end
      end
   end

endmodule

// File: tb/tb_demux1_4_buf.sv
// tb/tb_demux1_4_buf.sv - directed self-checking bench for demux1_4_buf
module tb_demux1_4_buf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] InData;
   logic        InValid;
   logic [1:0]  S;
   logic        InReady;
   logic [63:0] OutData;
   logic [3:0]  OutValid;
   logic [3:0]  OutReady;
   logic [11:0] Level;

   int n_checks = 0;
   int n_fail   = 0;

   demux1_4_buf #(.WIDTH(16), .DEPTH(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .InData   (InData),
      .InValid  (InValid),
      .S        (S),
      .InReady  (InReady),
      .OutData  (OutData),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .Level    (Level)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] od(input int ch);
      return OutData[ch*16 +: 16];
   endfunction

   function automatic logic [2:0] lvl(input int ch);
      return Level[ch*3 +: 3];
   endfunction

   initial begin
      rst_n = 1'b0; InValid = 1'b0; S = 2'd0; InData = 16'h0; OutReady = 4'h0;

      // Reset state
      tick(); tick();
      check("rst_outvalid", 64'(OutValid), 64'h0);
      check("rst_level",    64'(Level),    64'h0);
      check("rst_inready",  64'(InReady),  64'h0);
      check("rst_outdata",  OutData,       64'h0);
      rst_n = 1'b1;
      #1;
      check("rel_inready",  64'(InReady),  64'h1);
      tick();
      check("idle_outvalid", 64'(OutValid), 64'h0);
      check("idle_level",    64'(Level),    64'h0);

      // Single push to channel 2
      InValid = 1'b1; S = 2'd2; InData = 16'hA001;
      tick();
      InValid = 1'b0;
      check("ch2_outvalid", 64'(OutValid), 64'h4);
      check("ch2_data",     64'(od(2)),    64'hA001);
      check("ch2_level",    64'(Level),    64'h040);
      OutReady = 4'b0100;
      tick();
      OutReady = 4'b0000;
      check("ch2_drained",  64'(OutValid), 64'h0);

      // Channel 1: fill, stall third word, then drain in order
      InValid = 1'b1; S = 2'd1; InData = 16'h0001;
      tick();
      InData = 16'h0002;
      tick();
      check("ch1_level2",   64'(Level),    64'h010);
      InData = 16'h0003;
      #1;
      check("ch1_full_rdy", 64'(InReady),  64'h0);
      tick();
      check("ch1_hold_lvl", 64'(Level),    64'h010);
      check("ch1_head1",    64'(od(1)),    64'h0001);
      OutReady = 4'b0010;
      tick();
      check("ch1_lvl_pop1", 64'(lvl(1)),   64'h1);
      check("ch1_head2",    64'(od(1)),    64'h0002);
      check("ch1_rdy_open", 64'(InReady),  64'h1);
      tick();
      InValid = 1'b0;
      check("ch1_lvl_pp",   64'(lvl(1)),   64'h1);
      check("ch1_head3",    64'(od(1)),    64'h0003);
      tick();
      OutReady = 4'b0000;
      check("ch1_empty",    64'(OutValid), 64'h0);

      // Channel 0 full with simultaneous pop: slot opens one cycle later
      InValid = 1'b1; S = 2'd0; InData = 16'hB001;
      tick();
      InData = 16'hB002;
      tick();
      check("ch0_level2",   64'(lvl(0)),   64'h2);
      InData = 16'hB003; OutReady = 4'b0001;
      #1;
      check("ch0_full_rdy", 64'(InReady),  64'h0);
      tick();
      OutReady = 4'b0000;
      check("ch0_lvl_pop",  64'(lvl(0)),   64'h1);
      check("ch0_head2",    64'(od(0)),    64'hB002);
      check("ch0_rdy_next", 64'(InReady),  64'h1);
      tick();
      InValid = 1'b0;
      check("ch0_lvl_back", 64'(lvl(0)),   64'h2);
      check("ch0_head_keep", 64'(od(0)),   64'hB002);
      OutReady = 4'b0001;
      tick();
      check("ch0_head3",    64'(od(0)),    64'hB003);
      tick();
      OutReady = 4'b0000;
      check("ch0_empty",    64'(OutValid), 64'h0);

      // Round-robin streaming with all consumers ready
      OutReady = 4'hF;
      for (int k = 0; k < 100; k++) begin
         InValid = 1'b1; S = 2'(k % 4); InData = 16'hC000 + 16'(k);
         #1;
         check("rr_inready",  64'(InReady),  64'h1);
         tick();
         check("rr_outvalid", 64'(OutValid), 64'(4'b0001 << (k % 4)));
         check("rr_data",     64'(od(k % 4)), 64'(16'hC000 + 16'(k)));
         check("rr_level",    64'(Level),    64'(12'h001 << (3 * (k % 4))));
      end
      InValid = 1'b0;
      tick();
      check("rr_drained",   64'(OutValid), 64'h0);

      // Fill every channel, then reset asynchronously mid-cycle
      OutReady = 4'h0;
      InValid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         S = 2'(k / 2); InData = 16'hD000 + 16'(k);
         tick();
      end
      InValid = 1'b0;
      check("fill_level",   64'(Level),    64'h492);
      check("fill_valid",   64'(OutValid), 64'hF);
      S = 2'd3;
      #1;
      check("fill_rdy3",    64'(InReady),  64'h0);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_valid",   64'(OutValid), 64'h0);
      check("arst_level",   64'(Level),    64'h0);
      check("arst_rdy",     64'(InReady),  64'h0);
      check("arst_data",    OutData,       64'h0);
      tick();
      rst_n = 1'b1;
      #1;
      check("post_rdy",     64'(InReady),  64'h1);
      tick();
      check("post_valid",   64'(OutValid), 64'h0);
      check("post_level",   64'(Level),    64'h0);
      InValid = 1'b1; S = 2'd3; InData = 16'hE001;
      tick();
      InValid = 1'b0;
      check("post_ch3_valid", 64'(OutValid), 64'h8);
      check("post_ch3_data",  64'(od(3)),    64'hE001);
      check("post_ch3_level", 64'(Level),    64'h200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
